// File: rtl/mem_lsu.sv
// mem_lsu: load/store initiator for a dual-read/single-write word memory.
// Handles one request at a time. Word stores go straight to the write port.
// Loads and sub-word stores read the word first and wait out the memory's
// fixed read latency. Sub-word stores then write back the merged word.
// Optional build macro: MEM_MISALIGN_TRAP_EN. When it is defined, misaligned
// half/word requests complete with resp_fault=1 and make no memory access.
module mem_lsu #(
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_fault,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        mem_wen,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [7:0]  cnt_r, cnt_s;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        signed_q, we_q;
  logic        accept_s, latch_s, misalign_s;
  logic        resp_valid_s, resp_fault_s;
  logic [31:0] resp_data_s;
  logic        resp_valid_r, resp_fault_r;
  logic [31:0] resp_data_r;

  // Pick the addressed lane out of a memory word and zero/sign-extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  lo,
                                               input logic [1:0]  size,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lo, 3'b000} +: 8];
    h = word[{lo[1], 4'b0000} +: 16];
    case (size)
      2'd0:    res = {{24{sgn & b[7]}}, b};
      2'd1:    res = {{16{sgn & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace the addressed lane of the old word with the right-aligned store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wd,
                                              input logic [1:0]  lo,
                                              input logic [1:0]  size);
    logic [31:0] res;
    res = word;
    case (size)
      2'd0:    res[{lo, 3'b000} +: 8] = wd[7:0];
      2'd1:    res[{lo[1], 4'b0000} +: 16] = wd[15:0];
      default: res = wd;
    endcase
    return res;
  endfunction

  // Ready only out of reset and with nothing outstanding.
  assign req_ready = rst_n && (state_r == ST_IDLE);
  assign accept_s  = req_valid && req_ready;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_s = ((req_size == 2'd1) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misalign_s = 1'b0;
`endif

  // Next-state, memory port drive and response computation.
  always_comb begin
    state_s      = state_r;
    cnt_s        = 8'd0;
    latch_s      = 1'b0;
    mem_raddr    = addr_q;
    mem_wen      = 1'b0;
    mem_waddr    = {addr_q[31:2], 2'b00};
    mem_wdata    = 32'h0000_0000;
    resp_valid_s = 1'b0;
    resp_data_s  = 32'h0000_0000;
    resp_fault_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        mem_raddr = req_addr;
        if (accept_s) begin
          latch_s = 1'b1;
          if (misalign_s) begin
            resp_valid_s = 1'b1;
            resp_fault_s = 1'b1;
          end else if (req_we && req_size[1]) begin
            // Full-word store needs no read: write now, answer next cycle.
            mem_wen      = 1'b1;
            mem_waddr    = {req_addr[31:2], 2'b00};
            mem_wdata    = req_wdata;
            resp_valid_s = 1'b1;
          end else if (RD_LAT > 1) begin
            state_s = ST_WAIT;
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          latch_s = 1'b0;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 8'(RD_LAT - 2)) begin
          state_s = ST_DATA;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      ST_DATA: begin
        // mem_rdata holds the word addressed at accept time.
        state_s      = ST_IDLE;
        resp_valid_s = 1'b1;
        if (we_q) begin
          if (!size_q[1]) begin
            mem_wen   = 1'b1;
            mem_wdata = store_merge(mem_rdata, wdata_q, addr_q[1:0], size_q);
          end else begin
            mem_wen = 1'b0;
          end
        end else begin
          resp_data_s = load_extract(mem_rdata, addr_q[1:0], size_q, signed_q);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Capture request fields on accept for use in later cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= 32'h0000_0000;
      wdata_q  <= 32'h0000_0000;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      we_q     <= 1'b0;
    end else if (latch_s) begin
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      size_q   <= req_size;
      signed_q <= req_signed;
      we_q     <= req_we;
    end
  end

  // Response pulse; data and fault hold between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_r <= 1'b0;
      resp_data_r  <= 32'h0000_0000;
      resp_fault_r <= 1'b0;
    end else begin
      resp_valid_r <= resp_valid_s;
      if (resp_valid_s) begin
        resp_data_r  <= resp_data_s;
        resp_fault_r <= resp_fault_s;
      end
    end
  end

  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_data_r;
  assign resp_fault = resp_fault_r;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed bench for mem_lsu with a 2-cycle-latency memory model.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_data;
  logic [31:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
  logic        mem_wen;

  int n_cmp = 0;
  int n_err = 0;
  int wen_events = 0;

  mem_lsu #(.RD_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_fault(resp_fault), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  // Memory model: address in cycle C, data valid during C+2.
  logic [31:0] mem_model [0:255] = '{default: 32'h0000_0000};
  logic [31:0] rd_p1 = 32'h0, rd_p2 = 32'h0;
  always @(posedge clk) begin
    rd_p1 <= mem_model[mem_raddr[9:2]];
    rd_p2 <= rd_p1;
    if (mem_wen) mem_model[mem_waddr[9:2]] <= mem_wdata;
  end
  assign mem_rdata = rd_p2;

  // Count every write the DUT actually commits.
  always @(posedge clk) if (mem_wen) wen_events <= wen_events + 1;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
    int          exp_wen;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one request at the current point (caller sits just after a negedge
  // with the DUT idle) and follow it until resp_valid or a cycle budget.
  task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] data, output logic fault, output int lat,
                         output int wen_cnt, output int wen_cyc,
                         output logic [31:0] waddr, output logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    #1;
    lat = 0; wen_cnt = 0; wen_cyc = -1; data = 32'h0; fault = 1'b0;
    waddr = 32'h0; wd = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      if (mem_wen) begin
        wen_cnt++; wen_cyc = k - 1; waddr = mem_waddr; wd = mem_wdata;
      end
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      #1;
      if (resp_valid) begin
        lat = k; data = resp_data; fault = resp_fault;
        break;
      end
    end
  endtask

  logic [31:0] r_data, r_waddr, r_wd;
  logic        r_fault;
  int          r_lat, r_wen, r_wcyc, base;

  initial begin
    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0,        1, 1};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 3, 0};
    vecs[2]  = '{1'b0, 2'd0, 1'b1, 32'h101, 32'h0,        32'hFFFFFFBE, 3, 0};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h101, 32'h0,        32'h000000BE, 3, 0};
    vecs[4]  = '{1'b0, 2'd1, 1'b1, 32'h102, 32'h0,        32'hFFFFDEAD, 3, 0};
    vecs[5]  = '{1'b0, 2'd1, 1'b0, 32'h100, 32'h0,        32'h0000BEEF, 3, 0};
    vecs[6]  = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0,        32'hFFFFFFDE, 3, 0};
    vecs[7]  = '{1'b1, 2'd1, 1'b0, 32'h106, 32'h1234ABCD, 32'h0,        3, 1};
    vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h104, 32'h0,        32'hABCD0000, 3, 0};
    vecs[9]  = '{1'b1, 2'd0, 1'b0, 32'h108, 32'h00000077, 32'h0,        3, 1};
    vecs[10] = '{1'b0, 2'd0, 1'b0, 32'h108, 32'h0,        32'h00000077, 3, 0};
    vecs[11] = '{1'b0, 2'd1, 1'b1, 32'h104, 32'h0,        32'h00000000, 3, 0};
    vecs[12] = '{1'b0, 2'd3, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 3, 0};

    // Reset held with a word store presented.
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h100; req_wdata = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_wen", {31'd0, mem_wen}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk); #1;
    check("rel_ready", {31'd0, req_ready}, 32'd1);
    check("rst_no_write", wen_events, 0);

    // Table-driven requests, issued back to back.
    for (int i = 0; i < 13; i++) begin
      run_req(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
              r_data, r_fault, r_lat, r_wen, r_wcyc, r_waddr, r_wd);
      check($sformatf("v%0d_data", i), r_data, vecs[i].exp_data);
      check($sformatf("v%0d_fault", i), {31'd0, r_fault}, 32'd0);
      check($sformatf("v%0d_lat", i), r_lat, vecs[i].exp_lat);
      check($sformatf("v%0d_wen", i), r_wen, vecs[i].exp_wen);
      if (i == 0) begin
        check("v0_wen_cycle", r_wcyc, 0);
        check("v0_waddr", r_waddr, 32'h100);
      end
    end

    // Response data holds between pulses.
    repeat (2) @(negedge clk);
    #1;
    check("hold_valid", {31'd0, resp_valid}, 32'd0);
    check("hold_data", resp_data, 32'hDEADBEEF);

    // Byte store merge, then a back-to-back word load of the merged word.
    run_req(1'b1, 2'd0, 1'b0, 32'h102, 32'h00000012, r_data, r_fault, r_lat, r_wen, r_wcyc, r_waddr, r_wd);
    check("rmw_wen_cnt", r_wen, 1);
    check("rmw_wen_cycle", r_wcyc, 2);
    check("rmw_waddr", r_waddr, 32'h100);
    check("rmw_wdata", r_wd, 32'hDE12BEEF);
    check("rmw_lat", r_lat, 3);
    check("b2b_ready", {31'd0, req_ready}, 32'd1);
    run_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, r_data, r_fault, r_lat, r_wen, r_wcyc, r_waddr, r_wd);
    check("b2b_data", r_data, 32'hDE12BEEF);
    check("b2b_lat", r_lat, 3);

    // Reset in C+1 of a sub-word store: nothing written, no response.
    base = wen_events;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h100; req_wdata = 32'h00000055;
    @(negedge clk);
    req_valid = 1'b0; rst_n = 1'b0;
    #1;
    r_wen = 0;
    for (int k = 0; k < 3; k++) begin
      if (mem_wen || resp_valid) r_wen++;
      @(negedge clk); #1;
    end
    rst_n = 1'b1;
    check("rst_mid_activity", r_wen, 0);
    check("rst_mid_writes", wen_events - base, 0);
    @(negedge clk); #1;
    run_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, r_data, r_fault, r_lat, r_wen, r_wcyc, r_waddr, r_wd);
    check("rst_mid_word", r_data, 32'hDE12BEEF);

    // Misaligned half load at 0x103.
    base = wen_events;
    run_req(1'b0, 2'd1, 1'b0, 32'h103, 32'h0, r_data, r_fault, r_lat, r_wen, r_wcyc, r_waddr, r_wd);
`ifdef MEM_MISALIGN_TRAP_EN
    check("mis_lat", r_lat, 1);
    check("mis_fault", {31'd0, r_fault}, 32'd1);
    check("mis_data", r_data, 32'h0);
`else
    check("mis_lat", r_lat, 3);
    check("mis_fault", {31'd0, r_fault}, 32'd0);
    check("mis_data", r_data, 32'h0000DE12);
`endif
    check("mis_writes", wen_events - base, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
